// File: rtl/hi_tx_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | hi_tx_pkg : shared modulation-mode encodings for the HF transmitter |
// | Revision  : 1.0                                                     |
// +--------------------------------------------------------------------+
package hi_tx_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_FULL    = 2'b00;
    localparam mode_t MODE_SHALLOW = 2'b01;
    localparam mode_t MODE_OFF     = 2'b10;
    localparam mode_t MODE_ON      = 2'b11;

    localparam int ADC_W = 8;

    // Only the two modulating modes feed the pause watchdog.
    function automatic logic mode_modulates(input mode_t m);
        return (m == MODE_FULL) || (m == MODE_SHALLOW);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hi_hysteresis.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | hi_hysteresis : registered ADC sample, hysteresis and debounce      |
// | Revision      : 1.0                                                 |
// +--------------------------------------------------------------------+
module hi_hysteresis #(
    parameter int ADC_W    = 8,
    parameter int HYST_HI  = 255,
    parameter int HYST_LO  = 0,
    parameter int DEBOUNCE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [ADC_W-1:0] i_adc,
    output logic             o_rx
);

    localparam logic [ADC_W-1:0] c_hi       = ADC_W'(HYST_HI);
    localparam logic [ADC_W-1:0] c_lo       = ADC_W'(HYST_LO);
    localparam logic [3:0]       c_run_last = 4'(DEBOUNCE - 1);

    logic [ADC_W-1:0] r_adc;
    logic [3:0]       r_run;
    logic             r_rx;
    logic             w_qual;

    // A sample qualifies only if it pushes toward the opposite state.
    assign w_qual = r_rx ? (r_adc <= c_lo) : (r_adc >= c_hi);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_adc <= '0;
            r_run <= '0;
            r_rx  <= 1'b0;
        end else begin
            r_adc <= i_adc;
            if (w_qual) begin
                if (r_run == c_run_last) begin
                    r_rx  <= ~r_rx;
                    r_run <= '0;
                end else begin
                    r_run <= r_run + 4'd1;
                end
            end else begin
                r_run <= '0;
            end
        end
    end

    assign o_rx = r_rx;

endmodule
`default_nettype wire

// File: rtl/hi_tx_mod.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | hi_tx_mod : 13.56 MHz reader transmit modulator with SSP interface  |
// | Revision  : 1.0                                                     |
// +--------------------------------------------------------------------+
module hi_tx_mod
    import hi_tx_pkg::*;
#(
    parameter int DIV_W     = 7,
    parameter int FRAME_LEN = 8,
    parameter int HYST_HI   = 255,
    parameter int HYST_LO   = 0,
    parameter int DEBOUNCE  = 1,
    parameter int MAX_PAUSE = 2047
) (
    input  logic             ck_1356meg,
    input  logic             ck_1356megb,
    input  logic             reset_n,
    input  logic [ADC_W-1:0] adc_d,
    output logic             adc_clk,
    input  logic             ssp_dout,
    input  logic [1:0]       mod_mode,
    output logic             ssp_clk,
    output logic             ssp_frame,
    output logic             ssp_din,
    output logic             pwr_hi,
    output logic             pwr_lo,
    output logic             pwr_oe1,
    output logic             pwr_oe2,
    output logic             pwr_oe3,
    output logic             pwr_oe4,
    output logic             pause_err,
    output logic             dbg
);

    localparam int c_frame_w = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int c_pause_w = $clog2(MAX_PAUSE + 1);

    localparam logic [DIV_W-1:0]     c_div_max     = '1;
    localparam logic [DIV_W-1:0]     c_div_half_m1 = DIV_W'((1 << (DIV_W - 1)) - 1);
    localparam logic [c_frame_w-1:0] c_frame_last  = c_frame_w'(FRAME_LEN - 1);
    localparam logic [c_pause_w-1:0] c_pause_max   = c_pause_w'(MAX_PAUSE);

    logic [DIV_W-1:0]     r_div;
    logic [c_frame_w-1:0] r_frame;
    logic                 r_ssp_frame;
    logic                 r_mod_q;
    mode_t                r_mode_q;
    logic [c_pause_w-1:0] r_pause_cnt;
    logic                 r_pause_err;

    logic                 w_div_wrap;
    logic                 w_frame_wrap;
    logic [c_frame_w-1:0] w_frame_next;
    logic [c_pause_w-1:0] w_pause_next;
    logic                 w_mod_eff;
    logic                 w_rx;

    assign w_div_wrap   = (r_div == c_div_max);
    assign w_frame_wrap = w_div_wrap && (r_frame == c_frame_last);

    always_comb begin
        w_frame_next = r_frame;
        if (w_div_wrap) begin
            w_frame_next = (r_frame == c_frame_last) ? '0 : r_frame + 1'b1;
        end
    end

    always_comb begin
        w_pause_next = '0;
        if (mode_modulates(r_mode_q) && !r_mod_q) begin
            w_pause_next = (r_pause_cnt == c_pause_max) ? c_pause_max : r_pause_cnt + 1'b1;
        end
    end

    always_ff @(posedge ck_1356meg or negedge reset_n) begin
        if (!reset_n) begin
            r_div       <= '0;
            r_frame     <= '0;
            r_ssp_frame <= 1'b1;
            r_mod_q     <= 1'b1;
            r_mode_q    <= MODE_OFF;
            r_pause_cnt <= '0;
            r_pause_err <= 1'b0;
        end else begin
            r_div       <= r_div + 1'b1;
            r_frame     <= w_frame_next;
            r_ssp_frame <= (w_frame_next == '0);
            if (r_div == c_div_half_m1) begin
                r_mod_q <= ssp_dout;
            end
            // Mode only changes on frame boundaries so a frame is never split.
            if (w_frame_wrap) begin
                r_mode_q <= mod_mode;
            end
            r_pause_cnt <= w_pause_next;
            r_pause_err <= (w_pause_next == c_pause_max);
        end
    end

    assign w_mod_eff = r_mod_q | r_pause_err;

    always_comb begin
        pwr_hi  = 1'b0;
        pwr_oe4 = 1'b0;
        case (r_mode_q)
            MODE_FULL:    pwr_hi = ck_1356megb & w_mod_eff;
            MODE_SHALLOW: begin
                pwr_hi  = ck_1356megb;
                pwr_oe4 = ~w_mod_eff;
            end
            MODE_ON:      pwr_hi = ck_1356megb;
            default:      pwr_hi = 1'b0;
        endcase
    end

    hi_hysteresis #(
        .ADC_W    (ADC_W),
        .HYST_HI  (HYST_HI),
        .HYST_LO  (HYST_LO),
        .DEBOUNCE (DEBOUNCE)
    ) u_hyst (
        .clk   (ck_1356meg),
        .rst_n (reset_n),
        .i_adc (adc_d),
        .o_rx  (w_rx)
    );

    assign adc_clk   = ck_1356meg;
    assign ssp_clk   = r_div[DIV_W-1];
    assign ssp_frame = r_ssp_frame;
    assign ssp_din   = w_rx;
    assign dbg       = w_rx;
    assign pause_err = r_pause_err;
    assign pwr_lo    = 1'b0;
    assign pwr_oe1   = 1'b0;
    assign pwr_oe2   = 1'b0;
    assign pwr_oe3   = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_hi_tx_mod.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_hi_tx_mod : default and small-parameter instances vs. a model    |
// | Revision     : 1.0                                                  |
// +--------------------------------------------------------------------+
module tb_hi_tx_mod;

    logic       ck = 1'b0;
    logic       ckb;
    logic       reset_n = 1'b0;
    logic       ssp_dout = 1'b1;
    logic [1:0] mod_mode = 2'b00;
    logic [7:0] adc_d = 8'd0;

    assign ckb = ~ck;
    always #5 ck = ~ck;

    logic a_adc_clk, a_ssp_clk, a_ssp_frame, a_ssp_din, a_pwr_hi, a_pwr_lo;
    logic a_oe1, a_oe2, a_oe3, a_oe4, a_pause_err, a_dbg;
    logic b_adc_clk, b_ssp_clk, b_ssp_frame, b_ssp_din, b_pwr_hi, b_pwr_lo;
    logic b_oe1, b_oe2, b_oe3, b_oe4, b_pause_err, b_dbg;

    hi_tx_mod u_dut_a (
        .ck_1356meg(ck), .ck_1356megb(ckb), .reset_n(reset_n), .adc_d(adc_d),
        .adc_clk(a_adc_clk), .ssp_dout(ssp_dout), .mod_mode(mod_mode),
        .ssp_clk(a_ssp_clk), .ssp_frame(a_ssp_frame), .ssp_din(a_ssp_din),
        .pwr_hi(a_pwr_hi), .pwr_lo(a_pwr_lo), .pwr_oe1(a_oe1), .pwr_oe2(a_oe2),
        .pwr_oe3(a_oe3), .pwr_oe4(a_oe4), .pause_err(a_pause_err), .dbg(a_dbg)
    );

    hi_tx_mod #(
        .DIV_W(3), .FRAME_LEN(3), .HYST_HI(200), .HYST_LO(50), .DEBOUNCE(3), .MAX_PAUSE(20)
    ) u_dut_b (
        .ck_1356meg(ck), .ck_1356megb(ckb), .reset_n(reset_n), .adc_d(adc_d),
        .adc_clk(b_adc_clk), .ssp_dout(ssp_dout), .mod_mode(mod_mode),
        .ssp_clk(b_ssp_clk), .ssp_frame(b_ssp_frame), .ssp_din(b_ssp_din),
        .pwr_hi(b_pwr_hi), .pwr_lo(b_pwr_lo), .pwr_oe1(b_oe1), .pwr_oe2(b_oe2),
        .pwr_oe3(b_oe3), .pwr_oe4(b_oe4), .pause_err(b_pause_err), .dbg(b_dbg)
    );

    // Per-instance parameters as seen by the model.
    int p_per [2] = '{128, 8};
    int p_flen[2] = '{8, 3};
    int p_hi  [2] = '{255, 200};
    int p_lo  [2] = '{0, 50};
    int p_deb [2] = '{1, 3};
    int p_max [2] = '{2047, 20};

    // Model state: edges since reset, sampled modulation bit, active mode,
    // consecutive pause length, received bit, qualifying run, held ADC sample.
    int m_n[2], m_mod[2], m_mode[2], m_pc[2], m_rx[2], m_run[2], m_adcq[2];

    int    total = 0;
    int    bad   = 0;
    string phase = "reset";

    typedef struct { logic [7:0] adc; logic exp_din; } hvec_t;
    hvec_t tab[$];

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_n[k] = 0; m_mod[k] = 1; m_mode[k] = 2; m_pc[k] = 0;
            m_rx[k] = 0; m_run[k] = 0; m_adcq[k] = 0;
        end
    endtask

    task automatic model_edge();
        if (!reset_n) begin
            model_reset();
        end else begin
            for (int k = 0; k < 2; k++) begin
                if ((m_rx[k] == 1) ? (m_adcq[k] <= p_lo[k]) : (m_adcq[k] >= p_hi[k])) begin
                    m_run[k]++;
                    if (m_run[k] == p_deb[k]) begin
                        m_rx[k]  = 1 - m_rx[k];
                        m_run[k] = 0;
                    end
                end else begin
                    m_run[k] = 0;
                end
                m_adcq[k] = int'(adc_d);
                if (m_mode[k] <= 1 && m_mod[k] == 0)
                    m_pc[k] = (m_pc[k] < p_max[k]) ? m_pc[k] + 1 : p_max[k];
                else
                    m_pc[k] = 0;
                m_n[k]++;
                if (m_n[k] % p_per[k] == p_per[k] / 2) m_mod[k] = int'(ssp_dout);
                if (m_n[k] % (p_per[k] * p_flen[k]) == 0) m_mode[k] = int'(mod_mode);
            end
        end
    endtask

    // Expected outputs while the carrier clock is low (inverted carrier high).
    function automatic logic [11:0] expect_out(input int k);
        logic perr, eff, hi, oe4, sclk, sfr, rx;
        perr = (m_pc[k] == p_max[k]);
        eff  = (m_mod[k] == 1) || perr;
        sclk = ((m_n[k] % p_per[k]) >= p_per[k] / 2);
        sfr  = (((m_n[k] / p_per[k]) % p_flen[k]) == 0);
        rx   = (m_rx[k] == 1);
        hi   = (m_mode[k] == 0) ? eff : (m_mode[k] != 2);
        oe4  = (m_mode[k] == 1) && !eff;
        return {1'b0, sclk, sfr, rx, rx, hi, oe4, perr, 4'b0000};
    endfunction

    function automatic logic [11:0] get_out(input int k);
        if (k == 0)
            return {a_adc_clk, a_ssp_clk, a_ssp_frame, a_ssp_din, a_dbg, a_pwr_hi,
                    a_oe4, a_pause_err, a_pwr_lo, a_oe1, a_oe2, a_oe3};
        return {b_adc_clk, b_ssp_clk, b_ssp_frame, b_ssp_din, b_dbg, b_pwr_hi,
                b_oe4, b_pause_err, b_pwr_lo, b_oe1, b_oe2, b_oe3};
    endfunction

    task automatic check_all();
        cmp({phase, "_outs_a"}, 32'(get_out(0)), 32'(expect_out(0)));
        cmp({phase, "_outs_b"}, 32'(get_out(1)), 32'(expect_out(1)));
    endtask

    task automatic step();
        @(posedge ck);
        model_edge();
        #6;
        check_all();
    endtask

    initial begin
        int fcnt, zeros, hi_cnt, r;

        tab.push_back('{8'd255, 1'b0}); tab.push_back('{8'd255, 1'b0}); tab.push_back('{8'd0,   1'b0});
        tab.push_back('{8'd255, 1'b0}); tab.push_back('{8'd255, 1'b0}); tab.push_back('{8'd255, 1'b1});
        tab.push_back('{8'd100, 1'b1}); tab.push_back('{8'd30,  1'b1}); tab.push_back('{8'd30,  1'b1});
        tab.push_back('{8'd100, 1'b1}); tab.push_back('{8'd30,  1'b1}); tab.push_back('{8'd30,  1'b1});
        tab.push_back('{8'd30,  1'b0}); tab.push_back('{8'd200, 1'b0}); tab.push_back('{8'd200, 1'b0});
        tab.push_back('{8'd199, 1'b0}); tab.push_back('{8'd200, 1'b0}); tab.push_back('{8'd200, 1'b0});
        tab.push_back('{8'd200, 1'b1}); tab.push_back('{8'd50,  1'b1}); tab.push_back('{8'd50,  1'b1});
        tab.push_back('{8'd50,  1'b0});

        model_reset();
        repeat (3) step();
        cmp("reset_frame_a", 32'(a_ssp_frame), 32'd1);
        cmp("reset_pwr_hi_a", 32'(a_pwr_hi), 32'd0);

        // Default instance: first mode load at cycle 1024, frame high 128 of 1024.
        reset_n = 1'b1;
        phase   = "frame";
        fcnt    = 0;
        for (int i = 0; i < 1023; i++) begin
            step();
            fcnt += int'(a_ssp_frame);
        end
        cmp("pre_wrap_pwr_hi", 32'(a_pwr_hi), 32'd0);
        step();
        fcnt += int'(a_ssp_frame);
        cmp("wrap_pwr_hi", 32'(a_pwr_hi), 32'd1);
        cmp("frame_high_count", 32'(fcnt), 32'd128);

        // Held-off carrier until the watchdog forces it back on.
        phase    = "pause";
        ssp_dout = 1'b0;
        zeros    = 0;
        for (int i = 0; i < 4000 && !a_pause_err; i++) begin
            step();
            if (!a_pause_err && !a_pwr_hi) zeros++;
        end
        cmp("pause_err_raised", 32'(a_pause_err), 32'd1);
        cmp("forced_pwr_hi", 32'(a_pwr_hi), 32'd1);
        cmp("pause_len", 32'(zeros), 32'd2047);
        ssp_dout = 1'b1;
        for (int i = 0; i < 400 && a_pause_err; i++) step();
        cmp("pause_err_cleared", 32'(a_pause_err), 32'd0);
        cmp("resume_pwr_hi", 32'(a_pwr_hi), 32'd1);

        // Asynchronous reset in the middle of a pause.
        phase    = "midreset";
        ssp_dout = 1'b0;
        for (int i = 0; i < 3000 && m_pc[0] != 1000; i++) step();
        cmp("pause_reached_1000", 32'(m_pc[0]), 32'd1000);
        cmp("b_forced_before_reset", 32'(b_pause_err), 32'd1);
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        cmp("midreset_pause_err", 32'(a_pause_err), 32'd0);
        cmp("midreset_pwr_hi", 32'(a_pwr_hi), 32'd0);
        repeat (2) step();
        ssp_dout = 1'b1;
        adc_d    = 8'd0;
        reset_n  = 1'b1;

        // Hysteresis/debounce vectors on the DEBOUNCE=3 instance.
        phase = "hyst";
        for (int i = 0; i <= tab.size(); i++) begin
            adc_d = (i < tab.size()) ? tab[i].adc : 8'd0;
            step();
            if (i > 0) cmp("hyst_tab", 32'(b_ssp_din), 32'(tab[i-1].exp_din));
        end

        // Randomized traffic against the model.
        phase = "random";
        for (int i = 0; i < 9000; i++) begin
            if ($urandom_range(0, 199) == 0) ssp_dout = ~ssp_dout;
            if ($urandom_range(0, 499) == 0) mod_mode = 2'($urandom_range(0, 3));
            r = int'($urandom_range(0, 9));
            adc_d = (r < 3) ? 8'd255 : (r < 6) ? 8'd0 : 8'($urandom_range(0, 255));
            step();
        end

        // Mid-frame mode change is deferred to the next frame wrap.
        phase    = "defer";
        mod_mode = 2'b00;
        ssp_dout = 1'b1;
        repeat (130) step();
        for (int i = 0; i < 1100 && (m_n[0] % 1024) != 0; i++) step();
        for (int i = 0; i < 400 && (m_n[0] % 1024) != 384; i++) step();
        mod_mode = 2'b10;
        hi_cnt   = 0;
        for (int i = 0; i < 1100; i++) begin
            step();
            if (!a_pwr_hi) break;
            hi_cnt++;
        end
        cmp("defer_len", 32'(hi_cnt), 32'd639);
        cmp("after_defer_pwr_hi", 32'(a_pwr_hi), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hi_tx_mod.md
HI_TX_MOD -- requirements
Module: hi_tx_mod

Interface
REQ-001 Parameter DIV_W, default 7, SSP clock divider width; ssp_clk = fc / 2^DIV_W.
REQ-002 Parameter FRAME_LEN, default 8, ssp_clk periods per ssp_frame; legal range 2..64.
REQ-003 Parameter HYST_HI, default 255, ADC level at or above which the received bit goes high.
REQ-004 Parameter HYST_LO, default 0, ADC level at or below which the received bit goes low; HYST_LO < HYST_HI.
REQ-005 Parameter DEBOUNCE, default 1, consecutive qualifying samples needed to flip the received bit; legal range 1..15.
REQ-006 Parameter MAX_PAUSE, default 2047, maximum consecutive fc cycles of carrier-off modulation before forced carrier-on.
REQ-007 ck_1356meg  in  1  sole clock, 13.56 MHz; all state updates on its rising edge.
REQ-008 reset_n  in  1  asynchronous, active-low reset.
REQ-009 ck_1356megb  in  1  inverted carrier, used only as combinational carrier source for pwr_hi.
REQ-010 adc_d  in  8  ADC sample; adc_clk  out  1  equals ck_1356meg.
REQ-011 ssp_dout  in  1  modulation bit from ARM (1 = carrier on).
REQ-012 mod_mode  in  2  00 full ASK, 01 shallow, 10 carrier off, 11 carrier on unmodulated.
REQ-013 ssp_clk, ssp_frame, ssp_din  out  1 each  SSP clock, frame strobe, received bit.
REQ-014 pwr_hi, pwr_lo, pwr_oe1, pwr_oe2, pwr_oe3, pwr_oe4  out  1 each  antenna drivers.
REQ-015 pause_err  out  1  high while carrier is forced on by the pause watchdog; dbg  out  1  equals ssp_din.

Function
REQ-016 div counter (DIV_W bits) increments every cycle, wraps to 0; ssp_clk = div MSB.
REQ-017 frame counter increments when div wraps all-ones -> 0; wraps FRAME_LEN-1 -> 0; ssp_frame = (frame counter == 0).
REQ-018 mod_q samples ssp_dout on the edge where div goes from 2^(DIV_W-1)-1 to 2^(DIV_W-1) (ssp_clk rise); held otherwise.
REQ-019 mode_q loads mod_mode only on the edge where frame counter wraps to 0; mode changes mid-frame are deferred.
REQ-020 Full (00): pwr_hi = ck_1356megb & mod_eff; pwr_oe4 = 0.
REQ-021 Shallow (01): pwr_hi = ck_1356megb; pwr_oe4 = ~mod_eff.
REQ-022 Off (10): pwr_hi = 0, pwr_oe4 = 0; On (11): pwr_hi = ck_1356megb, pwr_oe4 = 0.
REQ-023 pwr_lo, pwr_oe1, pwr_oe2, pwr_oe3 are constant 0.
REQ-024 Pause counter counts consecutive cycles with mod_q = 0 in modes 00/01, saturating at MAX_PAUSE; clears on mod_q = 1 or any other mode.
REQ-025 At count == MAX_PAUSE, pause_err = 1 and mod_eff = 1; otherwise mod_eff = mod_q; pause_err drops the cycle after mod_q returns to 1.
REQ-026 adc_d is registered every cycle; hysteresis acts on the registered value (one cycle latency).
REQ-027 With rx = 0, a run of DEBOUNCE consecutive samples >= HYST_HI sets rx = 1; with rx = 1, a run of DEBOUNCE consecutive samples <= HYST_LO clears rx; a non-qualifying sample resets the run counter.
REQ-028 ssp_din = rx.

Reset
REQ-029 On reset_n low: div, frame counter, pause counter, run counter, rx = 0; mod_q = 1; mode_q = 10 (off).
REQ-030 Hence during reset pwr_hi = 0, ssp_frame = 1, ssp_clk = 0, pause_err = 0, ssp_din = 0.
REQ-031 Reset release mid-frame restarts counting from div = 0, frame = 0; first mode load is at the next frame wrap.

Structure
REQ-032 Mode encodings (MODE_FULL, MODE_SHALLOW, MODE_OFF, MODE_ON) live in shared package hi_tx_pkg.
REQ-033 Hysteresis plus debounce is sub-module hi_hysteresis (parameters ADC_W, HYST_HI, HYST_LO, DEBOUNCE).
REQ-034 Only pwr_hi/pwr_oe4 gating is combinational; all other outputs are register-driven.

Verification
REQ-035 Defaults, mod_mode = 00, ssp_dout = 1 -> mode_q = 00 at cycle 1024 (first frame wrap); ssp_clk period 128 cycles; ssp_frame high for 128 of every 1024 cycles.
REQ-036 Mode 00, ssp_dout = 0 held -> pwr_hi = 0 until pause count reaches 2047, then pwr_hi follows ck_1356megb and pause_err = 1; ssp_dout = 1 clears pause_err.
REQ-037 Mode 01, ssp_dout toggled per ssp_clk -> pwr_oe4 = ~ssp_dout sampled at ssp_clk rise; pwr_hi always follows ck_1356megb.
REQ-038 DEBOUNCE = 3, adc_d = 255,255,0,255,255,255 -> ssp_din rises 1 cycle after the final 255 only.
REQ-039 mod_mode changed 00 -> 10 at frame counter 3 -> pwr_hi stays modulated until frame wrap, then 0.
REQ-040 reset_n asserted mid-pause at count 1000 -> pause counter 0, pwr_hi = 0, pause_err = 0 immediately.
